// File: rtl/alu_issue_seq.sv
// -----------------------------------------------------------------------------
// alu_issue_seq
//
// Upstream sequencer for the 32-bit ALU. Accepts one operation per request
// handshake and registers operands/opcode onto the ALU inputs. For MOD it
// pulses the modulo unit's restart and waits out its iteration count. It then
// captures the ALU result and offers it on a response handshake. Only one
// operation is in flight at a time.
//
// Parameters:
//   MOD_CYCLES   cycles the modulo unit needs after its clear pulse (>= 1)
//   DIV0_RESULT  result returned for MOD with a zero divisor
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   req_valid/req_ready   request handshake; req_a, req_b, req_op payload
//   alu_a, alu_b, alu_op  registered operands/opcode driven to the ALU
//   alu_mod_clr           one-cycle restart pulse to the modulo unit
//   alu_result            result returned by the ALU
//   rsp_valid/rsp_ready   response handshake; rsp_result, rsp_op, rsp_err
//
// Optional build macro ALU_SEQ_STATS_EN adds op_count (16b, completed
// responses) and err_count (8b, completed divide-by-zero responses).
// -----------------------------------------------------------------------------
module alu_issue_seq #(
  parameter int unsigned MOD_CYCLES  = 40,
  parameter logic [31:0] DIV0_RESULT = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [2:0]  req_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  output logic        alu_mod_clr,
  input  logic [31:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [2:0]  rsp_op,
  output logic        rsp_err
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [15:0] op_count,
  output logic [7:0]  err_count
`endif
);

  localparam logic [2:0] OP_MOD = 3'b010;

  // Wide enough to hold MOD_CYCLES-1, never narrower than one bit.
  localparam int unsigned           CNT_W    = (MOD_CYCLES > 1) ? $clog2(MOD_CYCLES) : 1;
  localparam logic [CNT_W-1:0]      CNT_LOAD = CNT_W'(MOD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_MCLR,
    S_MWAIT,
    S_RESP
  } state_e;

  state_e             state_q, state_d;
  logic               ready_q, ready_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic [2:0]         op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        res_q, res_d;
  logic [2:0]         rop_q, rop_d;
  logic               err_q, err_d;

  logic accept;
  logic rsp_fire;

  assign accept   = req_valid && ready_q;
  assign rsp_fire = (state_q == S_RESP) && rsp_ready;

  // NOTE: every signal assigned in this block gets a default first; a missing
  // default on any branch would infer a latch.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    rop_d   = rop_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d  = req_a;
          b_d  = req_b;
          op_d = req_op;
          if (req_op != OP_MOD) begin
            state_d = S_EXEC;
          end else if (req_b != '0) begin
            state_d = S_MCLR;
          end else begin
            // Divide by zero never touches the modulo unit.
            state_d = S_RESP;
            res_d   = DIV0_RESULT;
            rop_d   = req_op;
            err_d   = 1'b1;
          end
        end
      end
      S_EXEC: begin
        res_d   = alu_result;
        rop_d   = op_q;
        err_d   = 1'b0;
        state_d = S_RESP;
      end
      S_MCLR: begin
        cnt_d   = CNT_LOAD;
        state_d = S_MWAIT;
      end
      S_MWAIT: begin
        if (cnt_q == '0) begin
          res_d   = alu_result;
          rop_d   = op_q;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Ready is registered so it is low for the cycle following a reset edge
    // and high on every cycle the FSM sits in IDLE afterwards.
    ready_d = (state_d == S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      rop_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      rop_q   <= rop_d;
      err_q   <= err_d;
    end
  end

  assign req_ready   = ready_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_op      = op_q;
  assign alu_mod_clr = (state_q == S_MCLR);
  assign rsp_valid   = (state_q == S_RESP);
  assign rsp_result  = res_q;
  assign rsp_op      = rop_q;
  assign rsp_err     = err_q;

`ifdef ALU_SEQ_STATS_EN
  logic [15:0] op_count_q;
  logic [7:0]  err_count_q;

  // Both counters wrap naturally at full scale.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_count_q  <= '0;
      err_count_q <= '0;
    end else if (rsp_fire) begin
      op_count_q <= op_count_q + 16'd1;
      if (err_q) err_count_q <= err_count_q + 8'd1;
    end
  end

  assign op_count  = op_count_q;
  assign err_count = err_count_q;
`else
  logic unused_rsp_fire;
  assign unused_rsp_fire = rsp_fire;
`endif

endmodule

// File: tb/tb_alu_issue_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_seq
//
// Self-checking bench for alu_issue_seq. The bench plays the ALU (including a
// modulo unit whose result is garbage until MOD_CYCLES cycles after its clear
// pulse) and predicts each response from the operation semantics: result
// value, opcode, error flag, handshake latency and clear-pulse count.
// Define ALU_SEQ_STATS_EN to also check the statistics counters.
// -----------------------------------------------------------------------------
module tb_alu_issue_seq;

  localparam int unsigned MOD_CYCLES  = 40;
  localparam logic [31:0] DIV0_RESULT = 32'hFFFF_FFFF;
  localparam logic [31:0] GARBAGE     = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [2:0]  req_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic        alu_mod_clr;
  logic [31:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [2:0]  rsp_op;
  logic        rsp_err;
`ifdef ALU_SEQ_STATS_EN
  logic [15:0] op_count;
  logic [7:0]  err_count;
`endif

  int n_vec = 0;
  int n_err = 0;
  int exp_ops  = 0;
  int exp_errs = 0;

  always #5 clk = ~clk;

  alu_issue_seq #(
    .MOD_CYCLES (MOD_CYCLES),
    .DIV0_RESULT(DIV0_RESULT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_mod_clr(alu_mod_clr),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_op     (rsp_op),
    .rsp_err    (rsp_err)
`ifdef ALU_SEQ_STATS_EN
    ,
    .op_count   (op_count),
    .err_count  (err_count)
`endif
  );

  // ---------------------------------------------------------------- ALU model
  function automatic logic [31:0] alu_func(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op);
    case (op)
      3'b000: return a + b;
      3'b001: return a - b;
      3'b010: return (b == 0) ? 32'd0 : a % b;
      3'b011: return a ^ b;
      3'b100: return a & b;
      3'b101: return a | b;
      3'b110: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return ~(a | b);
    endcase
  endfunction

  // Cycles completed since the modulo unit was last cleared.
  int mod_age = 1000;
  always @(posedge clk) begin
    if (alu_mod_clr) mod_age <= 0;
    else if (mod_age < 1000) mod_age <= mod_age + 1;
  end

  always_comb begin
    if (alu_op == 3'b010 && mod_age < int'(MOD_CYCLES) - 1) alu_result = GARBAGE;
    else alu_result = alu_func(alu_a, alu_b, alu_op);
  end

  // ---------------------------------------------------------------- checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Presents a request and waits for the accept edge; returns at the negedge
  // just after that edge with req_valid dropped. ok=0 if never accepted.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       output bit ok);
    int waited = 0;
    req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
    while (req_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    ok = (waited < 20);
    check("accept_timeout", 32'(ok), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    req_a = $urandom; req_b = $urandom; req_op = 3'($urandom);
  endtask

  // One full transaction, response held back for 'hold' cycles.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       input int hold);
    bit          ok;
    bit          is_mod;
    bit          div0;
    int          n, clr_n, clr_at, exp_lat;
    logic [31:0] exp_res;

    is_mod  = (op == 3'b010);
    div0    = is_mod && (b == 0);
    exp_res = div0 ? DIV0_RESULT : alu_func(a, b, op);
    exp_lat = !is_mod ? 2 : (div0 ? 1 : int'(MOD_CYCLES) + 2);

    issue(a, b, op, ok);
    if (!ok) return;

    // n counts cycles after the accept edge; we are now in cycle 1.
    n = 1; clr_n = 0; clr_at = 0;
    check("alu_a", alu_a, a);
    check("alu_b", alu_b, b);
    check("alu_op", 32'(alu_op), 32'(op));
    while (rsp_valid !== 1'b1 && n < 200) begin
      if (alu_mod_clr === 1'b1) begin clr_n++; clr_at = n; end
      if (req_ready !== 1'b0) check("ready_busy", 32'(req_ready), 32'd0);
      @(negedge clk);
      n++;
    end
    check("latency", n, exp_lat);
    check("clr_pulses", clr_n, (is_mod && !div0) ? 1 : 0);
    if (is_mod && !div0) check("clr_cycle", clr_at, 1);
    check("rsp_result", rsp_result, exp_res);
    check("rsp_op", 32'(rsp_op), 32'(op));
    check("rsp_err", 32'(rsp_err), 32'(div0));
    check("ready_resp", 32'(req_ready), 32'd0);

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_result", rsp_result, exp_res);
      check("hold_ready", 32'(req_ready), 32'd0);
    end
    check("hold_op_err", {28'd0, rsp_err, rsp_op}, {28'd0, div0, op});

    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_ops++;
    if (div0) exp_errs++;
    check("valid_drop", 32'(rsp_valid), 32'd0);
    check("ready_after", 32'(req_ready), 32'd1);
  endtask

  task automatic check_stats();
`ifdef ALU_SEQ_STATS_EN
    check("op_count", 32'(op_count), 32'(exp_ops[15:0]));
    check("err_count", 32'(err_count), 32'(exp_errs[7:0]));
`endif
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    bit ok;
    int idle_valid;

    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_op = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_alu", alu_a | alu_b | 32'(alu_op) | 32'(alu_mod_clr), 32'd0);
    check("rst_rsp", rsp_result | 32'(rsp_op) | 32'(rsp_err), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_post_rst", 32'(req_ready), 32'd1);
    check_stats();

    // Directed cases.
    do_op(32'd5, 32'd7, 3'b000, 0);              // add -> 12
    do_op(32'd50, 32'd9, 3'b010, 0);             // mod -> 5
    do_op(32'd50, 32'd0, 3'b010, 1);             // divide by zero
    check_stats();                               // 3 ops, 1 error
    do_op(32'hFFFF_FFFD, 32'd2, 3'b110, 10);     // slt under backpressure -> 1

    // Reset 10 cycles into MWAIT: no response may ever appear.
    issue(32'd1000, 32'd7, 3'b010, ok);
    if (ok) begin
      repeat (11) @(negedge clk);                // cycle 12 after accept
      reset = 1'b1;
      @(negedge clk);
      check("abort_valid", 32'(rsp_valid), 32'd0);
      check("abort_ready", 32'(req_ready), 32'd0);
      check("abort_clr", 32'(alu_mod_clr), 32'd0);
      reset = 1'b0;
      exp_ops = 0; exp_errs = 0;
      @(negedge clk);
      check("abort_ready_up", 32'(req_ready), 32'd1);
      idle_valid = 0;
      repeat (60) begin
        @(negedge clk);
        if (rsp_valid !== 1'b0) idle_valid++;
      end
      check("abort_no_rsp", idle_valid, 0);
      check_stats();
    end

    // Randomised traffic.
    for (int k = 0; k < 40; k++) begin
      logic [31:0] a, b;
      logic [2:0]  op;
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) a = a >> $urandom_range(0, 31);
      do_op(a, b, op, int'($urandom_range(0, 3)));
    end
    check_stats();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/alu_issue_seq.md
Name: alu_issue_seq

Overview:
- Upstream sequencer for the 32-bit ALU. Accepts one operation request per transaction over a valid/ready handshake and registers the operands and opcode.
- Holds the registered values stable on the ALU inputs. For MOD it restarts the iterative modulo unit and waits for it to finish.
- Captures the ALU result and presents it downstream over a second valid/ready handshake.
- Only one operation is in flight at a time.

Parameters:
- MOD_CYCLES, 40: number of clock cycles the modulo unit needs after its clear pulse before its result is valid; minimum 1.
- DIV0_RESULT, 32'hFFFF_FFFF: result returned for MOD when the divisor is zero.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_a  in  32  operand A.
- req_b  in  32  operand B.
- req_op  in  3  ALUop encoding: 000 add, 001 sub, 010 mod, 011 xor, 100 and, 101 or, 110 slt, 111 nor.
- alu_a  out  32  registered operand A to the ALU.
- alu_b  out  32  registered operand B to the ALU.
- alu_op  out  3  registered opcode to the ALU.
- alu_mod_clr  out  1  one-cycle restart pulse to the ALU modulo unit.
- alu_result  in  32  ALU result.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  32  captured result.
- rsp_op  out  3  opcode of the completed operation.
- rsp_err  out  1  set when the response is a MOD with divisor zero.

Behaviour:
- Reset values: req_ready=0 during reset, and 1 on the first cycle after reset deasserts. All of the following are 0: alu_a, alu_b, alu_op, alu_mod_clr, rsp_valid, rsp_result, rsp_op, rsp_err. Cycle counter = 0.
- Reset has priority over all other inputs in any state. Reset mid-operation abandons the operation with no response, and the state becomes IDLE.
- FSM states are IDLE, EXEC, MCLR, MWAIT, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch a/b/op into alu_a/alu_b/alu_op. Next state:
  - op!=010: EXEC.
  - op==010 and b!=0: MCLR.
  - op==010 and b==0: RESP directly, with rsp_result=DIV0_RESULT and rsp_err=1.
- EXEC: a single cycle. alu_result is captured into rsp_result at the end of this cycle; rsp_err=0. Next state is RESP. A non-MOD op therefore reaches rsp_valid=1 two cycles after the accept edge.
- MCLR: alu_mod_clr=1 for exactly this cycle; counter loads MOD_CYCLES-1. Next state is MWAIT.
- MWAIT: counter decrements each cycle. When counter==0, alu_result is captured into rsp_result at the end of this cycle and the next state is RESP. MOD latency from the accept edge to rsp_valid is MOD_CYCLES+2 cycles.
- RESP: rsp_valid=1. rsp_result, rsp_op and rsp_err are stable until rsp_valid&&rsp_ready. On that handshake, rsp_valid drops on the next edge and the state becomes IDLE.
- There is no same-cycle accept on response completion. Minimum request-to-request spacing is 4 cycles for non-MOD ops.
- req_ready=0 in every state except IDLE.
- alu_a, alu_b and alu_op hold their last value after completion until the next accept. alu_mod_clr=0 in every state except MCLR.
- Requests presented while req_ready=0 are ignored and must be held by the producer.

Optional Feature:
- Macro ALU_SEQ_STATS_EN.
- When defined, two extra output ports are added:
  - op_count (16 bits): increments on each rsp_valid&&rsp_ready.
  - err_count (8 bits): increments on each such handshake with rsp_err=1.
- Both counters wrap at full scale and reset to 0.
- When not defined, neither port nor counter exists and behaviour is otherwise identical.

Test Plan:
- Add: req a=5, b=7, op=000 -> alu_a=5/alu_b=7 the cycle after accept; rsp_valid 2 cycles after accept with rsp_result=12, rsp_op=000, rsp_err=0.
- Mod with MOD_CYCLES=40: a=50, b=9, op=010 -> alu_mod_clr high exactly 1 cycle, the one after accept; rsp_valid 42 cycles after accept with rsp_result=5.
- Backpressure: slt a=-3 (32'hFFFF_FFFD), b=2, hold rsp_ready=0 for 10 cycles -> rsp_result=1 stable and req_ready=0 throughout; new request accepted only after the handshake.
- Divide by zero: a=50, b=0, op=010 -> no alu_mod_clr pulse; rsp_valid 1 cycle after accept with rsp_result=32'hFFFF_FFFF and rsp_err=1.
- Reset mid-MOD: assert reset 10 cycles into MWAIT -> next cycle rsp_valid=0 and req_ready=0; the cycle after reset deasserts, req_ready=1; no response ever issued for the aborted op.
- With ALU_SEQ_STATS_EN defined: 3 completed ops including 1 divide-by-zero -> op_count=3, err_count=1.
